// File: rtl/async_rx_pkg.sv
// Shared defaults for the click-to-clocked receive bridge.
// Occupancy counter width covers 0..DEPTH inclusive.
package async_rx_pkg;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int CNT_W           = $clog2(DEF_DEPTH) + 1;
endpackage

// File: rtl/toggle_sync.sv
// Synchronises a 2-phase toggle into clk and emits a 1-cycle pulse per transition.
// Latency: SYNC_STAGES edges from first sampling edge to pulse; no backpressure.
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tog,
    output logic o_event
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   d_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            d_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_tog};
            d_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_event = sync_q[SYNC_STAGES-1] ^ d_prev;
endmodule

// File: rtl/async_rx_bridge.sv
// Click bundled-data to valid/ready bridge with FWFT FIFO; ASYNC_RX_PROTO_CHK_EN adds o_proto_err.
// Latency: drive edge sampled at edge k is written at edge k+SYNC_STAGES.
// Backpressure: full FIFO parks one token as pending and withholds o_free until a pop frees space.
module async_rx_bridge
    import async_rx_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_drive,
    input  logic [DATA_W-1:0] i_data_32,
    output logic              o_free,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready,
    output logic [CW-1:0]     o_count
`ifdef ASYNC_RX_PROTO_CHK_EN
    ,
    output logic              o_proto_err
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pending;
    logic              drv_event;
    logic              pop;
    logic              push;
    logic              has_room;

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_tog   (i_drive),
        .o_event (drv_event)
    );

    assign o_valid  = (o_count != '0);
    assign o_data   = o_valid ? mem[rd_ptr] : '0;
    assign pop      = o_valid && i_ready;
    assign has_room = (o_count < CW'(DEPTH)) || pop;
    // An event arriving while a token is already parked is dropped: push serves the parked one.
    assign push     = (drv_event || pending) && has_room;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
            o_free  <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                o_free  <= ~o_free;
                pending <= 1'b0;
            end else if (drv_event) begin
                pending <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            o_count <= o_count + CW'(push) - CW'(pop);
        end
    end

    // Upstream holds i_data_32 until o_free toggles, so a parked token is still readable here.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= i_data_32;
        end
    end

`ifdef ASYNC_RX_PROTO_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_proto_err <= 1'b0;
        end else if (drv_event && pending) begin
            o_proto_err <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_async_rx_bridge.sv
// Self-checking bench for async_rx_bridge at DATA_W=32, DEPTH=4, SYNC_STAGES=2.
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_async_rx_bridge;
    import async_rx_pkg::*;

    localparam int DEPTH = DEF_DEPTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_drive;
    logic [31:0]      i_data_32;
    logic             o_free;
    logic             o_valid;
    logic [31:0]      o_data;
    logic             i_ready;
    logic [CNT_W-1:0] o_count;
`ifdef ASYNC_RX_PROTO_CHK_EN
    logic             o_proto_err;
`endif

    int   n_run  = 0;
    int   n_fail = 0;
    logic exp_free = 1'b0;
    logic tb_drv   = 1'b0;

    always #5 clk = ~clk;

    async_rx_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .i_drive   (i_drive),
        .i_data_32 (i_data_32),
        .o_free    (o_free),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .i_ready   (i_ready),
        .o_count   (o_count)
`ifdef ASYNC_RX_PROTO_CHK_EN
        ,
        .o_proto_err (o_proto_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tok(input logic [31:0] d);
        i_data_32 = d;
        tb_drv    = ~tb_drv;
        i_drive   = tb_drv;
    endtask

    task automatic wait_free(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (o_free === exp_free) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        i_drive   = 1'b1;
        i_data_32 = $urandom;
        i_ready   = 1'b1;
        tick();
        i_drive = 1'b0;
        tb_drv  = 1'b0;
        tick();
        n_run++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_run++; if (o_free !== 1'b0) begin n_fail++; $display("FAIL reset_free: got %b want 0", o_free); end
        n_run++; if (o_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_count); end
        n_run++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", o_data); end
        rst      = 1'b0;
        i_ready  = 1'b0;
        exp_free = 1'b0;
        tick();
    endtask

    task automatic test_single();
        i_ready = 1'b0;
        send_tok(32'hDEADBEEF);
        tick();
        tick();
        n_run++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", o_valid); end
        tick();
        exp_free = ~exp_free;
        n_run++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", o_valid); end
        n_run++; if (o_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h want deadbeef", o_data); end
        n_run++; if (o_free !== 1'b1) begin n_fail++; $display("FAIL single_free: got %b want 1", o_free); end
        n_run++; if (o_count !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", o_count); end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        n_run++; if (o_count !== 0 || o_data !== 32'h0) begin n_fail++; $display("FAIL single_pop: count %0d data %h want 0/0", o_count, o_data); end
    endtask

    task automatic test_full_pending();
        bit ok;
        bit moved;
        i_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_tok(32'(i));
            exp_free = ~exp_free;
            wait_free(ok);
            n_run++; if (!ok) begin n_fail++; $display("FAIL fill_ack: token %0d got no o_free toggle, o_free=%b", i, o_free); end
        end
        n_run++; if (o_count !== 4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", o_count); end
        send_tok(32'h5);
        moved = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_free !== exp_free) moved = 1'b1;
        end
        n_run++; if (moved) begin n_fail++; $display("FAIL pending_no_ack: o_free toggled=%b want 0", moved); end
        n_run++; if (o_count !== 4 || o_data !== 32'h1) begin n_fail++; $display("FAIL pending_state: count %0d head %h want 4/1", o_count, o_data); end
        i_ready = 1'b1;
        tick();
        i_ready  = 1'b0;
        exp_free = ~exp_free;
        n_run++; if (o_free !== exp_free) begin n_fail++; $display("FAIL resolve_free: got %b want %b", o_free, exp_free); end
        n_run++; if (o_count !== 4) begin n_fail++; $display("FAIL resolve_count: got %0d want 4", o_count); end
        i_ready = 1'b1;
        for (int j = 2; j <= 5; j++) begin
            n_run++; if (o_data !== 32'(j)) begin n_fail++; $display("FAIL drain_order: got %h want %h", o_data, 32'(j)); end
            tick();
        end
        i_ready = 1'b0;
        n_run++; if (o_count !== 0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", o_count); end
    endtask

    task automatic test_streaming();
        logic [31:0] rec[$];
        int          maxc;
        bit          got;
        maxc    = 0;
        i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_tok(32'h10 + 32'(i));
            exp_free = ~exp_free;
            got = 1'b0;
            for (int c = 0; c < 30 && !got; c++) begin
                tick();
                if (o_valid) rec.push_back(o_data);
                if (int'(o_count) > maxc) maxc = int'(o_count);
                if (o_free === exp_free) got = 1'b1;
            end
            n_run++; if (!got) begin n_fail++; $display("FAIL stream_ack: token %0d no ack, o_free=%b", i, o_free); end
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            if (o_valid) rec.push_back(o_data);
        end
        i_ready = 1'b0;
        n_run++; if (rec.size() != 8) begin n_fail++; $display("FAIL stream_len: got %0d want 8", rec.size()); end
        for (int i = 0; i < 8 && i < rec.size(); i++) begin
            n_run++; if (rec[i] !== 32'h10 + 32'(i)) begin n_fail++; $display("FAIL stream_order: got %h want %h", rec[i], 32'h10 + 32'(i)); end
        end
        n_run++; if (maxc > 1) begin n_fail++; $display("FAIL stream_maxcount: got %0d want <=1", maxc); end
    endtask

    task automatic test_reset_midop();
        bit ok;
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_tok($urandom);
            exp_free = ~exp_free;
            wait_free(ok);
            n_run++; if (!ok) begin n_fail++; $display("FAIL midop_fill_ack: token %0d o_free=%b", i, o_free); end
        end
        n_run++; if (o_count !== 3) begin n_fail++; $display("FAIL midop_count: got %0d want 3", o_count); end
        rst     = 1'b1;
        i_drive = 1'b0;
        tb_drv  = 1'b0;
        tick();
        rst      = 1'b0;
        exp_free = 1'b0;
        n_run++; if (o_count !== 0 || o_valid !== 1'b0 || o_free !== 1'b0) begin
            n_fail++; $display("FAIL midop_reset: count %0d valid %b free %b want 0/0/0", o_count, o_valid, o_free);
        end
        tick();
        send_tok(32'hA5A55A5A);
        exp_free = ~exp_free;
        wait_free(ok);
        n_run++; if (!ok) begin n_fail++; $display("FAIL midop_post_ack: o_free=%b want %b", o_free, exp_free); end
        n_run++; if (o_data !== 32'hA5A55A5A || o_count !== 1) begin n_fail++; $display("FAIL midop_post_data: data %h count %0d want a5a55a5a/1", o_data, o_count); end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    // Reference: token becomes visible 3 edges after the drive toggle is applied;
    // it enters the queue when there is space after this edge's pop, otherwise it waits.
    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] up_data;
        bit          mpend;
        bit          outstanding;
        bit          pop;
        bit          ev;
        int          cd;
        logic [31:0] exp_head;
        mpend = 1'b0; outstanding = 1'b0; cd = 0; up_data = '0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            i_ready = (cyc >= 560) ? 1'b1 : 1'($urandom_range(0, 1));
            if (!outstanding && cyc < 540 && $urandom_range(0, 2) == 0) begin
                up_data = $urandom;
                send_tok(up_data);
                outstanding = 1'b1;
                cd = 3;
            end
            pop = (q.size() != 0) && i_ready;
            ev  = 1'b0;
            if (cd > 0) begin
                cd--;
                ev = (cd == 0);
            end
            if (pop) void'(q.pop_front());
            if ((ev || mpend) && q.size() < DEPTH) begin
                q.push_back(up_data);
                exp_free    = ~exp_free;
                mpend       = 1'b0;
                outstanding = 1'b0;
            end else if (ev) begin
                mpend = 1'b1;
            end
            tick();
            exp_head = (q.size() != 0) ? q[0] : 32'h0;
            n_run++; if (o_count !== CNT_W'(q.size())) begin n_fail++; $display("FAIL rand_count cyc %0d: got %0d want %0d", cyc, o_count, q.size()); end
            n_run++; if (o_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, o_valid, q.size() != 0); end
            n_run++; if (o_data !== exp_head) begin n_fail++; $display("FAIL rand_data cyc %0d: got %h want %h", cyc, o_data, exp_head); end
            n_run++; if (o_free !== exp_free) begin n_fail++; $display("FAIL rand_free cyc %0d: got %b want %b", cyc, o_free, exp_free); end
        end
        i_ready = 1'b0;
    endtask

`ifdef ASYNC_RX_PROTO_CHK_EN
    task automatic test_proto_err();
        bit ok;
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_tok($urandom);
            exp_free = ~exp_free;
            wait_free(ok);
            n_run++; if (!ok) begin n_fail++; $display("FAIL proto_fill_ack: token %0d o_free=%b", i, o_free); end
        end
        send_tok(32'h55);
        for (int i = 0; i < 6; i++) tick();
        n_run++; if (o_proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_early: got %b want 0", o_proto_err); end
        send_tok(32'h66);
        for (int i = 0; i < 6; i++) tick();
        n_run++; if (o_proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_set: got %b want 1", o_proto_err); end
        i_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        i_ready  = 1'b0;
        exp_free = ~exp_free;
        n_run++; if (o_count !== 0 || o_free !== exp_free) begin n_fail++; $display("FAIL proto_drain: count %0d free %b want 0/%b", o_count, o_free, exp_free); end
        n_run++; if (o_proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_sticky: got %b want 1", o_proto_err); end
        rst     = 1'b1;
        i_drive = 1'b0;
        tb_drv  = 1'b0;
        tick();
        rst      = 1'b0;
        exp_free = 1'b0;
        n_run++; if (o_proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_clear: got %b want 0", o_proto_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_full_pending();
        test_streaming();
        test_reset_midop();
        test_random();
`ifdef ASYNC_RX_PROTO_CHK_EN
        test_proto_err();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, run=%0d failed=%0d", n_run, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
